branch_predictor_btb: RTL and testbench

- Direct-mapped branch target buffer with per-entry saturating direction counters for the pipelined RV64 core.
- Sits beside the program counter in IF: it predicts next-PC for conditional branches and JAL from the current fetch PC.
- It is trained from ID, where branches resolve. It also reports mispredictions and a redirect PC to the fetch mux.
- Includes saturating performance counters and a whole-table invalidate.

---
 rtl/branch_predictor_btb_pkg.sv | 38 +++
 rtl/branch_predictor_btb_if.sv | 52 +++++
 rtl/branch_predictor_btb_sat_counter.sv | 30 +++
 rtl/branch_predictor_btb.sv | 143 ++++++++++++++
 tb/tb_branch_predictor_btb.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared types, defaults and helpers for the branch target buffer.
package branch_predictor_btb_pkg;

    // Default geometry of the BTB.
    localparam int BTB_XLEN    = 64;
    localparam int BTB_ENTRIES = 16;
    localparam int BTB_TAG_W   = 10;
    localparam int BTB_CTR_W   = 2;
    localparam int BTB_CNT_W   = 32;

    // RV64 control-transfer opcodes the predictor is concerned with.
    typedef enum logic [6:0] {
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    // Index width: smallest w with 2**w >= entries.
    function automatic int idx_width(input int entries);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < entries) w = i + 1;
        end
        return w;
    endfunction

    // Weakly-taken initial value for a freshly allocated branch counter.
    function automatic logic [31:0] ctr_weak_taken(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Strongly-taken initial value for a freshly allocated jump counter.
    function automatic logic [31:0] ctr_strong_taken(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup, ID training, redirect and perf-counter bundle of the BTB.
// Handshake: upd_valid qualifies all upd_* fields for exactly the cycle it is
// high; there is no ready, the BTB accepts every update (inv_all and reset
// may drop it). The fetch side has no handshake: f_pc is looked up every
// cycle and f_lookup_en only marks cycles that count as real lookups.
interface branch_predictor_btb_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  f_pc;
    logic             f_lookup_en;
    logic             f_hit;
    logic             f_pred_taken;
    logic [XLEN-1:0]  f_pred_target;

    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_is_jump;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;

    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;

    logic             inv_all;

    logic [CNT_W-1:0] perf_lookups;
    logic [CNT_W-1:0] perf_hits;
    logic [CNT_W-1:0] perf_mispredicts;

    // Core side: drives fetch PC, training and invalidate.
    modport master (
        output f_pc, f_lookup_en,
        output upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target, inv_all,
        input  f_hit, f_pred_taken, f_pred_target,
        input  mispredict, redirect_pc,
        input  perf_lookups, perf_hits, perf_mispredicts
    );

    // BTB side.
    modport slave (
        input  f_pc, f_lookup_en,
        input  upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target, inv_all,
        output f_hit, f_pred_taken, f_pred_target,
        output mispredict, redirect_pc,
        output perf_lookups, perf_hits, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter with load and set-to-max; clears on reset.
module branch_predictor_btb_sat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         dec,
    input  logic         set_max,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    // Priority: reset, load, set_max, then saturating inc/dec.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (set_max) begin
            count <= '1;
        end else if (inc && !dec && (count != '1)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry direction counters, trained from ID.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int XLEN    = BTB_XLEN,
    parameter int ENTRIES = BTB_ENTRIES,
    parameter int TAG_W   = BTB_TAG_W,
    parameter int CTR_W   = BTB_CTR_W,
    parameter int CNT_W   = BTB_CNT_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    branch_predictor_btb_if.slave bus
);

    localparam int IDX_W = idx_width(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT_BRANCH = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_INIT_JUMP   = CTR_W'(ctr_strong_taken(CTR_W));

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;

    logic upd_we;
    logic u_hit;
    logic alloc;
    logic tgt_we;
    logic ctr_inc;
    logic ctr_dec;
    logic ctr_max;
    logic ctr_load;
    logic [CTR_W-1:0] ctr_load_val;

    assign f_idx = bus.f_pc[IDX_W+1:2];
    assign f_tag = bus.f_pc[TAG_W+IDX_W+1:IDX_W+2];
    assign u_idx = bus.upd_pc[IDX_W+1:2];
    assign u_tag = bus.upd_pc[TAG_W+IDX_W+1:IDX_W+2];

    // Zero-latency lookup from the current table; no bypass of this cycle's update.
    always_comb begin
        bus.f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        bus.f_pred_taken  = bus.f_hit && ctr_q[f_idx][CTR_W-1];
        bus.f_pred_target = bus.f_pred_taken ? target_q[f_idx] : bus.f_pc + XLEN'(4);
    end

    // Misprediction detection and correct next PC for the fetch mux.
    always_comb begin
        bus.mispredict  = bus.upd_valid &&
                          ((bus.upd_taken != bus.upd_pred_taken) ||
                           (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
        bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);
    end

    // Training decode: an invalidate in the same cycle drops the update.
    always_comb begin
        upd_we       = bus.upd_valid && !bus.inv_all;
        u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        alloc        = upd_we && !u_hit && bus.upd_taken;
        tgt_we       = upd_we && (u_hit ? (bus.upd_is_jump || bus.upd_taken) : bus.upd_taken);
        ctr_inc      = upd_we && u_hit && !bus.upd_is_jump && bus.upd_taken;
        ctr_dec      = upd_we && u_hit && !bus.upd_is_jump && !bus.upd_taken;
        ctr_max      = upd_we && bus.upd_is_jump && (u_hit || bus.upd_taken);
        ctr_load     = alloc;
        ctr_load_val = bus.upd_is_jump ? CTR_INIT_JUMP : CTR_INIT_BRANCH;
    end

    // Valid bits: reset and invalidate clear everything, allocation sets one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (bus.inv_all) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

    // Tag and target storage; not reset, but a reset cycle still blocks the write.
    always_ff @(posedge clk) begin
        if (resetn && tgt_we) begin
            target_q[u_idx] <= bus.upd_target;
            if (alloc) tag_q[u_idx] <= u_tag;
        end
    end

    // One direction counter per entry, steered by the update index.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_dir
        logic sel;
        assign sel = (u_idx == IDX_W'(i));

        branch_predictor_btb_sat_counter #(.W(CTR_W)) u_dir (
            .clk      (clk),
            .resetn   (resetn),
            .inc      (ctr_inc && sel),
            .dec      (ctr_dec && sel),
            .set_max  (ctr_max && sel && !ctr_load),
            .load     (ctr_load && sel),
            .load_val (ctr_load_val),
            .count    (ctr_q[i])
        );
    end

    // Performance counters: increment-only, saturating, untouched by inv_all.
    branch_predictor_btb_sat_counter #(.W(CNT_W)) u_perf_lookups (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (bus.f_lookup_en),
        .dec      (1'b0),
        .set_max  (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .count    (bus.perf_lookups)
    );

    branch_predictor_btb_sat_counter #(.W(CNT_W)) u_perf_hits (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (bus.f_lookup_en && bus.f_hit),
        .dec      (1'b0),
        .set_max  (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .count    (bus.perf_hits)
    );

    branch_predictor_btb_sat_counter #(.W(CNT_W)) u_perf_mispredicts (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (bus.mispredict),
        .dec      (1'b0),
        .set_max  (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .count    (bus.perf_mispredicts)
    );

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb (16 entries, 2-bit counters, 4-bit perf counters).
module tb_branch_predictor_btb;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic clk;
    logic resetn;

    int tests_run;
    int tests_failed;
    int exp_misp;

    branch_predictor_btb_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus_if ();

    branch_predictor_btb #(
        .XLEN    (XLEN),
        .ENTRIES (16),
        .TAG_W   (10),
        .CTR_W   (2),
        .CNT_W   (CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    // Clock and timeout guard.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    // Single comparison point.
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [63:0] pc, input logic jump, input logic taken,
                           input logic [63:0] tgt, input logic ptaken, input logic [63:0] ptgt);
        bus_if.upd_valid       = 1'b1;
        bus_if.upd_pc          = pc;
        bus_if.upd_is_jump     = jump;
        bus_if.upd_taken       = taken;
        bus_if.upd_target      = tgt;
        bus_if.upd_pred_taken  = ptaken;
        bus_if.upd_pred_target = ptgt;
        #1;
    endtask

    task automatic clear_upd();
        bus_if.upd_valid       = 1'b0;
        bus_if.upd_pc          = '0;
        bus_if.upd_is_jump     = 1'b0;
        bus_if.upd_taken       = 1'b0;
        bus_if.upd_target      = '0;
        bus_if.upd_pred_taken  = 1'b0;
        bus_if.upd_pred_target = '0;
        #1;
    endtask

    task automatic upd_cycle(input logic [63:0] pc, input logic jump, input logic taken,
                             input logic [63:0] tgt, input logic ptaken, input logic [63:0] ptgt);
        set_upd(pc, jump, taken, tgt, ptaken, ptgt);
        step();
        clear_upd();
    endtask

    task automatic look(input string tag, input logic [63:0] pc, input logic hit,
                        input logic taken, input logic [63:0] tgt);
        bus_if.f_pc = pc;
        #1;
        check({tag, "_hit"},    {63'd0, bus_if.f_hit},        {63'd0, hit});
        check({tag, "_taken"},  {63'd0, bus_if.f_pred_taken}, {63'd0, taken});
        check({tag, "_target"}, bus_if.f_pred_target,         tgt);
    endtask

    task automatic check_perf(input string tag, input int lk, input int ht, input int mp);
        check({tag, "_lookups"}, 64'(bus_if.perf_lookups),     64'(lk));
        check({tag, "_hits"},    64'(bus_if.perf_hits),        64'(ht));
        check({tag, "_misp"},    64'(bus_if.perf_mispredicts), 64'(mp));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_misp     = 0;

        // Reset.
        resetn             = 1'b0;
        bus_if.f_pc        = '0;
        bus_if.f_lookup_en = 1'b0;
        bus_if.inv_all     = 1'b0;
        clear_upd();
        step();
        step();
        resetn = 1'b1;
        #1;

        look("reset_0x40", 64'h40, 1'b0, 1'b0, 64'h44);
        check_perf("reset", 0, 0, 0);

        // First allocation: same-cycle lookup sees the old (empty) entry.
        set_upd(64'h40, 1'b0, 1'b1, 64'h100, 1'b0, 64'h44);
        check("same_cycle_hit", {63'd0, bus_if.f_hit}, 64'd0);
        check("alloc_misp", {63'd0, bus_if.mispredict}, 64'd1);
        check("alloc_redirect", bus_if.redirect_pc, 64'h100);
        step();
        clear_upd();
        exp_misp = 1;
        look("after_alloc", 64'h40, 1'b1, 1'b1, 64'h100);

        // Counter 10 -> 01 -> 00 -> 01 -> 10.
        upd_cycle(64'h40, 1'b0, 1'b0, 64'h0, 1'b1, 64'h100);
        exp_misp = 2;
        look("nt1", 64'h40, 1'b1, 1'b0, 64'h44);
        upd_cycle(64'h40, 1'b0, 1'b0, 64'h0, 1'b1, 64'h100);
        exp_misp = 3;
        look("nt2", 64'h40, 1'b1, 1'b0, 64'h44);
        upd_cycle(64'h40, 1'b0, 1'b1, 64'h100, 1'b0, 64'h44);
        exp_misp = 4;
        look("t_from_00", 64'h40, 1'b1, 1'b0, 64'h44);
        upd_cycle(64'h40, 1'b0, 1'b1, 64'h100, 1'b0, 64'h44);
        exp_misp = 5;
        look("t_from_01", 64'h40, 1'b1, 1'b1, 64'h100);

        // Alias on index 0 with a different tag replaces the entry.
        set_upd(64'h80, 1'b0, 1'b1, 64'h200, 1'b1, 64'h200);
        check("alias_misp", {63'd0, bus_if.mispredict}, 64'd0);
        check("alias_redirect", bus_if.redirect_pc, 64'h200);
        step();
        clear_upd();
        look("alias_old", 64'h40, 1'b0, 1'b0, 64'h44);
        look("alias_new", 64'h80, 1'b1, 1'b1, 64'h200);

        // Jump allocates strongly taken: one not-taken leaves it predicted taken.
        upd_cycle(64'h1004, 1'b1, 1'b1, 64'h2000, 1'b1, 64'h2000);
        look("jump_alloc", 64'h1004, 1'b1, 1'b1, 64'h2000);
        upd_cycle(64'h1004, 1'b0, 1'b0, 64'h0, 1'b1, 64'h2000);
        exp_misp = 6;
        look("jump_after_nt", 64'h1004, 1'b1, 1'b1, 64'h2000);

        // Not-taken miss does not allocate.
        set_upd(64'h508, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        check("nt_miss_misp", {63'd0, bus_if.mispredict}, 64'd0);
        check("nt_miss_redirect", bus_if.redirect_pc, 64'h50C);
        step();
        clear_upd();
        look("nt_miss", 64'h508, 1'b0, 1'b0, 64'h50C);

        // Wrong target with right direction, then wrong direction.
        set_upd(64'h90C, 1'b0, 1'b1, 64'h300, 1'b1, 64'h100);
        check("tgt_misp", {63'd0, bus_if.mispredict}, 64'd1);
        check("tgt_redirect", bus_if.redirect_pc, 64'h300);
        step();
        exp_misp = 7;
        set_upd(64'h7C, 1'b0, 1'b0, 64'h0, 1'b1, 64'h80);
        check("dir_misp", {63'd0, bus_if.mispredict}, 64'd1);
        check("dir_redirect", bus_if.redirect_pc, 64'h80);
        step();
        exp_misp = 8;
        bus_if.upd_valid = 1'b0;
        #1;
        check("idle_misp", {63'd0, bus_if.mispredict}, 64'd0);
        clear_upd();
        check_perf("after_misp", 0, 0, exp_misp);

        // Lookups: three hits on 0x80, two misses on 0x40.
        bus_if.f_lookup_en = 1'b1;
        bus_if.f_pc        = 64'h80;
        step();
        step();
        step();
        bus_if.f_pc = 64'h40;
        step();
        step();
        bus_if.f_lookup_en = 1'b0;
        #1;
        check_perf("lookups", 5, 3, 8);

        // Invalidate wins over a simultaneous allocation.
        bus_if.inv_all = 1'b1;
        set_upd(64'hC00, 1'b0, 1'b1, 64'h10, 1'b1, 64'h10);
        step();
        bus_if.inv_all = 1'b0;
        clear_upd();
        look("inv_0x80",  64'h80,   1'b0, 1'b0, 64'h84);
        look("inv_0x1004", 64'h1004, 1'b0, 1'b0, 64'h1008);
        look("inv_0x90C", 64'h90C,  1'b0, 1'b0, 64'h910);
        look("inv_0xC00", 64'hC00,  1'b0, 1'b0, 64'hC04);
        check_perf("after_inv", 5, 3, 8);

        // Saturation: 20 more mispredicts and lookups on 4-bit counters.
        bus_if.f_pc        = 64'h40;
        bus_if.f_lookup_en = 1'b1;
        set_upd(64'h7C, 1'b0, 1'b0, 64'h0, 1'b1, 64'h80);
        for (int i = 0; i < 20; i++) step();
        bus_if.f_lookup_en = 1'b0;
        clear_upd();
        check_perf("saturate", 15, 3, 15);

        // Reset mid-operation discards the pending allocation and clears counters.
        resetn = 1'b0;
        set_upd(64'h40, 1'b0, 1'b1, 64'h100, 1'b0, 64'h44);
        step();
        resetn = 1'b1;
        clear_upd();
        look("rst_drop", 64'h40, 1'b0, 1'b0, 64'h44);
        check_perf("rst_mid", 0, 0, 0);

        // PC+4 wraps at the top of the address space.
        look("wrap_fetch", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);
        set_upd(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0);
        check("wrap_redirect", bus_if.redirect_pc, 64'h0);
        clear_upd();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
